// File: rtl/vcbu_chain_re_if.sv
// Bus bundle for the cascadable up-counter: the enables and load data go in,
// the counter state and the terminal flags come out.
interface vcbu_chain_re_if #(
  parameter int unsigned M = 4,
  parameter int unsigned N = 4
);
  logic         ce;
  logic         l;
  logic [M*N-1:0] di;
  logic [M*N-1:0] Q;
  logic [N-1:0] DTC;
  logic         TC;
  logic         CEO;

  modport master (output ce, l, di, input Q, DTC, TC, CEO);
  modport slave  (input ce, l, di, output Q, DTC, TC, CEO);
endinterface

// File: rtl/vcbu_chain_re.sv
// Cascadable multi-digit up-counter (per-digit modulus MOD) with synchronous
// clear, parallel load and count enable. TC/CEO let instances be chained.
module vcbu_chain_re #(
  parameter int unsigned M   = 4,
  parameter int unsigned N   = 4,
  parameter int unsigned MOD = 10
) (
  input  logic            clk,
  input  logic            r,
  vcbu_chain_re_if.slave  bus
);

  localparam logic [M-1:0] TERM = M'(MOD - 1);

  logic [M*N-1:0] q_q;
  logic [M*N-1:0] q_d;
  logic [N-1:0]   dtc;
  logic [N-1:0]   adv;

  // Per-digit terminal flags; an out-of-range digit is never terminal.
  always_comb begin
    dtc = '0;
    for (int unsigned k = 0; k < N; k++) begin
      dtc[k] = (q_q[k*M +: M] == TERM);
    end
  end

  // Carry chain: digit k advances only when every lower digit is terminal.
  // A running AND keeps the chain combinational within one cycle.
  always_comb begin
    logic carry;
    adv   = '0;
    carry = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      adv[k] = carry;
      carry  = carry & dtc[k];
    end
  end

  // Next state with priority reset > load > count.
  always_comb begin
    q_d = q_q;
    if (r) begin
      q_d = '0;
    end else if (bus.l) begin
      q_d = bus.di;
    end else if (bus.ce) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (adv[k]) begin
          if (q_q[k*M +: M] >= TERM) begin
            q_d[k*M +: M] = '0;
          end else begin
            q_d[k*M +: M] = q_q[k*M +: M] + 1'b1;
          end
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign bus.Q   = q_q;
  assign bus.DTC = dtc;
  assign bus.TC  = &dtc;
  assign bus.CEO = bus.ce & (&dtc);

endmodule

// File: tb/tb_vcbu_chain_re.sv
// Bench for vcbu_chain_re: a 4-digit BCD instance plus two chained 1-digit
// binary instances, checked every cycle against a value-level model and at
// fixed points against literal expectations.
module tb_vcbu_chain_re;

  localparam int unsigned M   = 4;
  localparam int unsigned N   = 4;
  localparam int unsigned MOD = 10;

  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  vcbu_chain_re_if #(.M(M), .N(N)) bcd ();
  vcbu_chain_re_if #(.M(4), .N(1)) lo ();
  vcbu_chain_re_if #(.M(4), .N(1)) hi ();

  vcbu_chain_re #(.M(M), .N(N), .MOD(MOD)) u_bcd (.clk(clk), .r(r), .bus(bcd));
  vcbu_chain_re #(.M(4), .N(1), .MOD(16))  u_lo  (.clk(clk), .r(r), .bus(lo));
  vcbu_chain_re #(.M(4), .N(1), .MOD(16))  u_hi  (.clk(clk), .r(r), .bus(hi));

  assign hi.ce = lo.CEO;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [15:0] m_q = '0;
  logic [7:0]  c_q = '0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Mixed-radix increment: in-range values are treated as one integer
  // modulo the full chain range; otherwise fall back to digit rules
  // (out-of-range digit -> 0, no carry).
  function automatic logic [15:0] inc_model(input logic [15:0] v);
    logic [15:0] res;
    int unsigned val, w, d;
    bit inr, carry;
    inr = 1'b1; val = 0; w = 1; res = v;
    for (int k = 0; k < N; k++) begin
      d = int'(v[k*M +: M]);
      if (d >= MOD) inr = 1'b0;
      val += d * w;
      w   *= MOD;
    end
    if (inr) begin
      val = (val + 1) % w;
      for (int k = 0; k < N; k++) begin
        res[k*M +: M] = M'(val % MOD);
        val = val / MOD;
      end
    end else begin
      carry = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (carry) begin
          d = int'(v[k*M +: M]);
          if (d == MOD - 1) res[k*M +: M] = '0;
          else if (d > MOD - 1) begin res[k*M +: M] = '0; carry = 1'b0; end
          else begin res[k*M +: M] = M'(d + 1); carry = 1'b0; end
        end
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] dtc_model(input logic [15:0] v);
    logic [3:0] f;
    for (int k = 0; k < N; k++) f[k] = (int'(v[k*M +: M]) == MOD - 1);
    return f;
  endfunction

  // Model update on each rising edge from the inputs presented to it.
  always @(posedge clk) begin
    if (r) begin
      m_q = '0; c_q = '0; chk_en = 1'b1;
    end else begin
      if (bcd.l) m_q = bcd.di;
      else if (bcd.ce) m_q = inc_model(m_q);
      if (lo.l) c_q = {hi.di, lo.di};
      else if (lo.ce) c_q = c_q + 8'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd_Q",   bcd.Q,   m_q);
      check("bcd_DTC", bcd.DTC, dtc_model(m_q));
      check("bcd_TC",  bcd.TC,  (dtc_model(m_q) == 4'hF));
      check("bcd_CEO", bcd.CEO, bcd.ce & (dtc_model(m_q) == 4'hF));
      check("casc_Q",  {hi.Q, lo.Q}, c_q);
      check("casc_lo_CEO", lo.CEO, lo.ce & (c_q[3:0] == 4'hF));
      check("casc_CEO", hi.CEO, lo.ce & (c_q == 8'hFF));
    end
  end

  task automatic step(input logic rr, input logic ll, input logic cc, input logic [15:0] dd);
    r = rr; bcd.l = ll; bcd.ce = cc; bcd.di = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic cstep(input logic rr, input logic ll, input logic cc, input logic [7:0] dd);
    r = rr; lo.l = ll; hi.l = ll; lo.ce = cc; {hi.di, lo.di} = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bcd.l = 1'b1; bcd.ce = 1'b1; bcd.di = 16'h1234;
    lo.l = 1'b0; hi.l = 1'b0; lo.ce = 1'b0; lo.di = '0; hi.di = '0;

    // Reset wins over load and count
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    step(1'b1, 1'b1, 1'b1, 16'h1234);
    check("lit_reset_Q",   bcd.Q, 16'h0000);
    check("lit_reset_TC",  bcd.TC, 1'b0);
    check("lit_reset_CEO", bcd.CEO, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 16'h0);
    check("lit_count5", bcd.Q, 16'h0005);

    // Decimal carry
    step(1'b0, 1'b1, 1'b0, 16'h0009);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("lit_carry1_Q",   bcd.Q, 16'h0010);
    check("lit_carry1_DTC", bcd.DTC, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 16'h0999);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("lit_carry3_Q", bcd.Q, 16'h1000);

    // Terminal state and wrap
    step(1'b0, 1'b1, 1'b0, 16'h9999);
    check("lit_term_TC",   bcd.TC, 1'b1);
    check("lit_term_DTC",  bcd.DTC, 4'b1111);
    check("lit_term_CEO0", bcd.CEO, 1'b0);
    bcd.l = 1'b0; bcd.ce = 1'b1; #1;
    check("lit_term_CEO1", bcd.CEO, 1'b1);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("lit_wrap_Q",  bcd.Q, 16'h0000);
    check("lit_wrap_TC", bcd.TC, 1'b0);

    // Hold and priority
    step(1'b0, 1'b1, 1'b0, 16'h0042);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
    check("lit_hold", bcd.Q, 16'h0042);
    step(1'b0, 1'b1, 1'b1, 16'h0100);
    check("lit_load_no_inc", bcd.Q, 16'h0100);
    step(1'b1, 1'b1, 1'b1, 16'h0777);
    check("lit_reset_over_load", bcd.Q, 16'h0000);

    // Out-of-range digit wraps without carry
    step(1'b0, 1'b1, 1'b0, 16'h000C);
    step(1'b0, 1'b0, 1'b1, 16'h0);
    check("lit_oor_wrap", bcd.Q, 16'h0000);

    // Terminal load with ce=1: loaded, not incremented
    step(1'b0, 1'b1, 1'b1, 16'h9999);
    check("lit_term_load_ce", bcd.Q, 16'h9999);
    check("lit_term_load_CEO", bcd.CEO, 1'b1);

    // Binary cascade of two 1-digit instances
    bcd.ce = 1'b0; bcd.l = 1'b0;
    cstep(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 255; i++) cstep(1'b0, 1'b0, 1'b1, 8'h00);
    check("lit_casc_FF",  {hi.Q, lo.Q}, 8'hFF);
    check("lit_casc_CEO", hi.CEO, 1'b1);
    cstep(1'b0, 1'b0, 1'b1, 8'h00);
    check("lit_casc_wrap", {hi.Q, lo.Q}, 8'h00);

    // Randomized traffic on both chains, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      r      = ($urandom_range(0, 63) == 0);
      bcd.l  = ($urandom_range(0, 9) == 0);
      bcd.ce = ($urandom_range(0, 9) < 7);
      bcd.di = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h9999 - 16'($urandom_range(0, 2));
      lo.l   = ($urandom_range(0, 19) == 0);
      hi.l   = lo.l;
      lo.ce  = ($urandom_range(0, 9) < 8);
      {hi.di, lo.di} = 8'($urandom);
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
